// File: rtl/tb_cmd_dispatcher.sv
// Sequential command dispatcher: latch one tokenised command, start its checker channel, await done or timeout, then ack.
// Optional macro TB_DISP_STATS_EN enables live command/error counters and a per-ACK log line.
module tb_cmd_dispatcher #(
  parameter int ARGS_NB   = 5,
  parameter int TIMEOUT_W = 32,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  string                i_args [ARGS_NB],
  input  logic                 i_args_valid,
  output logic                 o_args_ready,
  input  logic [TIMEOUT_W-1:0] i_timeout,
  output logic [3:0]           o_sel,
  output logic                 o_start,
  output logic                 o_wait_rise,
  output logic                 o_abort,
  input  logic [3:0]           i_done,
  input  logic [3:0]           i_error,
  output logic                 o_ack,
  output logic [1:0]           o_err_code,
  output logic                 o_busy,
  output logic [CNT_W-1:0]     o_cmd_cnt,
  output logic [CNT_W-1:0]     o_err_cnt
);

  typedef enum logic [1:0] {IDLE, DISPATCH, BUSY, ACK} state_t;

  localparam logic [1:0] CODE_OK  = 2'd0;
  localparam logic [1:0] CODE_UNK = 2'd1;
  localparam logic [1:0] CODE_TMO = 2'd2;
  localparam logic [1:0] CODE_CHN = 2'd3;

  state_t               state_q, state_d;
  string                args_q [ARGS_NB];
  logic                 armed_q;
  logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [1:0]           code_q, code_d;
  logic [3:0]           dec_sel;
  logic                 dec_rise;
  logic                 accept;
  logic                 sel_done;
  logic                 sel_err;
  logic                 tmo_hit;

  // Decode always works on the latched copy so later i_args changes are invisible.
  always_comb begin
    dec_sel  = 4'b0000;
    dec_rise = 1'b0;
    if (args_q[0] == "SET") begin
      dec_sel = 4'b0001;
    end else if (args_q[0] == "WTR") begin
      dec_sel  = 4'b0010;
      dec_rise = 1'b1;
    end else if (args_q[0] == "WTF") begin
      dec_sel = 4'b0010;
    end else if (args_q[0] == "CHK") begin
      dec_sel = 4'b0100;
    end else if (args_q[0] == "WTD") begin
      dec_sel = 4'b1000;
    end
  end

  // armed_q keeps ready low until the first edge after reset release.
  assign o_args_ready = armed_q && (state_q == IDLE);
  assign o_busy       = (state_q != IDLE);
  assign o_err_code   = code_q;
  assign accept       = o_args_ready && i_args_valid;
  assign sel_done     = |(i_done & dec_sel);
  assign sel_err      = |(i_error & dec_sel);
  assign tmo_hit      = (i_timeout != '0) && (tmo_cnt_q == i_timeout - 1'b1);

  always_comb begin
    state_d     = state_q;
    tmo_cnt_d   = tmo_cnt_q;
    code_d      = code_q;
    o_sel       = 4'b0000;
    o_start     = 1'b0;
    o_wait_rise = 1'b0;
    o_abort     = 1'b0;
    o_ack       = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = DISPATCH;
      end
      DISPATCH: begin
        o_sel       = dec_sel;
        o_wait_rise = dec_rise;
        tmo_cnt_d   = '0;
        if (dec_sel != 4'b0000) begin
          o_start = 1'b1;
          state_d = BUSY;
        end else begin
          code_d  = CODE_UNK;
          state_d = ACK;
        end
      end
      BUSY: begin
        o_sel       = dec_sel;
        o_wait_rise = dec_rise;
        // Done takes priority over a timeout landing in the same cycle.
        if (sel_done) begin
          code_d  = sel_err ? CODE_CHN : CODE_OK;
          state_d = ACK;
        end else if (tmo_hit) begin
          o_abort = 1'b1;
          code_d  = CODE_TMO;
          state_d = ACK;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      ACK: begin
        o_ack   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      armed_q   <= 1'b0;
      tmo_cnt_q <= '0;
      code_q    <= CODE_OK;
      for (int i = 0; i < ARGS_NB; i++) args_q[i] <= "";
    end else begin
      state_q   <= state_d;
      armed_q   <= 1'b1;
      tmo_cnt_q <= tmo_cnt_d;
      code_q    <= code_d;
      if (accept) begin
        for (int i = 0; i < ARGS_NB; i++) args_q[i] <= i_args[i];
      end
    end
  end

`ifdef TB_DISP_STATS_EN
  logic [CNT_W-1:0] cmd_cnt_q, err_cnt_q;

  function automatic string join_args();
    string s;
    s = "";
    for (int i = 0; i < ARGS_NB; i++) s = {s, " ", args_q[i]};
    return s;
  endfunction

  // Counters advance on the ACK exit edge and stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_cnt_q <= '0;
      err_cnt_q <= '0;
    end else if (state_q == ACK) begin
      if (cmd_cnt_q != '1) cmd_cnt_q <= cmd_cnt_q + 1'b1;
      if ((code_q != CODE_OK) && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 1'b1;
      $display("%0t tb_cmd_dispatcher: op=%s tokens=[%s ] code=%0d", $time, args_q[0], join_args(), code_q);
    end
  end

  assign o_cmd_cnt = cmd_cnt_q;
  assign o_err_cnt = err_cnt_q;
`else
  assign o_cmd_cnt = '0;
  assign o_err_cnt = '0;
`endif

endmodule

// File: tb/tb_tb_cmd_dispatcher.sv
// Self-checking bench for tb_cmd_dispatcher: directed scenarios plus randomized commands against a transaction-level model.
module tb_tb_cmd_dispatcher;
  localparam int ARGS_NB   = 5;
  localparam int TIMEOUT_W = 32;
  localparam int CNT_W     = 16;
`ifdef TB_DISP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  string                args [ARGS_NB];
  logic                 args_valid = 1'b0;
  logic [TIMEOUT_W-1:0] timeout = '0;
  logic [3:0]           done = 4'b0;
  logic [3:0]           error = 4'b0;
  logic                 args_ready, start, wait_rise, abort, ack, busy;
  logic [3:0]           sel;
  logic [1:0]           err_code;
  logic [CNT_W-1:0]     cmd_cnt, err_cnt;

  // Per-cycle expectations, set by the stimulus just after each rising edge.
  logic       e_ready = 0, e_start = 0, e_rise = 0, e_abort = 0, e_ack = 0, e_busy = 0;
  logic [3:0] e_sel = 0;
  logic [1:0] m_code = 0;
  int unsigned m_cmd = 0, m_err = 0;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, ack_cyc = -1, acc_cyc = -1, n_abort = 0;

  tb_cmd_dispatcher #(.ARGS_NB(ARGS_NB), .TIMEOUT_W(TIMEOUT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .i_args(args), .i_args_valid(args_valid), .o_args_ready(args_ready),
    .i_timeout(timeout), .o_sel(sel), .o_start(start), .o_wait_rise(wait_rise), .o_abort(abort),
    .i_done(done), .i_error(error), .o_ack(ack), .o_err_code(err_code), .o_busy(busy),
    .o_cmd_cnt(cmd_cnt), .o_err_cnt(err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint exp_cnt(input int unsigned v);
    if (!STATS) return 0;
    return (v > 32'((1 << CNT_W) - 1)) ? longint'((1 << CNT_W) - 1) : longint'(v);
  endfunction

  always @(negedge clk) begin
    chk("args_ready", args_ready, e_ready);
    chk("sel", sel, e_sel);
    chk("start", start, e_start);
    chk("wait_rise", wait_rise, e_rise);
    chk("abort", abort, e_abort);
    chk("ack", ack, e_ack);
    chk("busy", busy, e_busy);
    chk("err_code", err_code, m_code);
    chk("cmd_cnt", cmd_cnt, exp_cnt(m_cmd));
    chk("err_cnt", err_cnt, exp_cnt(m_err));
    if (ack) ack_cyc = cyc;
    if (abort) n_abort++;
    if (args_ready && args_valid) acc_cyc = cyc;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input logic rdy, input logic [3:0] s, input logic st, input logic rs,
                         input logic ab, input logic ak, input logic bz);
    e_ready = rdy; e_sel = s; e_start = st; e_rise = rs; e_abort = ab; e_ack = ak; e_busy = bz;
  endtask

  function automatic logic [3:0] model_sel(input string op);
    if (op == "SET") return 4'b0001;
    if (op == "WTR" || op == "WTF") return 4'b0010;
    if (op == "CHK") return 4'b0100;
    if (op == "WTD") return 4'b1000;
    return 4'b0000;
  endfunction

  // Called in an idle, ready cycle; returns in the idle cycle following the ack.
  task automatic do_cmd(input string op, input int tmo, input int done_k, input bit err,
                        input int spur_k, input bit disp_done);
    logic [3:0] s;
    logic       rs;
    logic [1:0] code;
    int         nb;
    s  = model_sel(op);
    rs = (op == "WTR");
    if (s == 4'b0000) begin
      nb = 0; code = 2'd1;
    end else if (done_k >= 0 && (tmo == 0 || done_k < tmo)) begin
      nb = done_k + 1; code = err ? 2'd3 : 2'd0;
    end else begin
      nb = tmo; code = 2'd2;
    end
    args[0] = op;
    for (int i = 1; i < ARGS_NB; i++) args[i] = $sformatf("t%0d", $urandom_range(0, 99));
    timeout    = TIMEOUT_W'(tmo);
    args_valid = 1'b1;
    step();
    args_valid = 1'b0;
    args[0] = (op == "CHK") ? "SET" : "CHK";
    for (int i = 1; i < ARGS_NB; i++) args[i] = "zz";
    done  = disp_done ? s : 4'b0;
    error = disp_done ? s : 4'b0;
    set_exp(0, s, s != 0, rs, 0, 0, 1);
    for (int k = 0; k < nb; k++) begin
      step();
      done = (k == done_k) ? s : 4'b0;
      if (k == spur_k) done = done | (~s & 4'($urandom_range(1, 15)));
      error = (k == done_k && err) ? s : (~s & 4'($urandom));
      set_exp(0, s, 0, rs, code == 2'd2 && k == nb - 1, 0, 1);
    end
    step();
    done = 4'b0; error = 4'b0;
    m_code = code;
    set_exp(0, 4'b0, 0, 0, 0, 1, 1);
    step();
    m_cmd++;
    if (code != 2'd0) m_err++;
    set_exp(1, 4'b0, 0, 0, 0, 0, 0);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    string ops [7];
    int    ab0;
    ops = '{"SET", "WTR", "WTF", "CHK", "WTD", "XYZ", "set"};
    for (int i = 0; i < ARGS_NB; i++) args[i] = "";
    set_exp(0, 4'b0, 0, 0, 0, 0, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    set_exp(1, 4'b0, 0, 0, 0, 0, 0);
    step();

    do_cmd("SET", 0, 0, 0, -1, 0);
    chk("set_latency", ack_cyc - acc_cyc, 3);
    chk("set_code", err_code, 0);
    chk("set_cmd_cnt", cmd_cnt, STATS ? 1 : 0);

    ab0 = n_abort;
    do_cmd("WTR", 10, -1, 0, -1, 0);
    chk("wtr_latency", ack_cyc - acc_cyc, 12);
    chk("wtr_abort_pulses", n_abort - ab0, 1);
    chk("wtr_code", err_code, 2);
    chk("wtr_err_cnt", err_cnt, STATS ? 1 : 0);

    do_cmd("XYZ", 0, 0, 0, -1, 0);
    chk("xyz_latency", ack_cyc - acc_cyc, 2);
    chk("xyz_code", err_code, 1);

    do_cmd("CHK", 0, 2, 1, 0, 1);
    chk("chk_latency", ack_cyc - acc_cyc, 5);
    chk("chk_code", err_code, 3);

    ab0 = n_abort;
    do_cmd("WTF", 4, 3, 0, -1, 0);
    chk("wtf_latency", ack_cyc - acc_cyc, 6);
    chk("wtf_no_abort", n_abort - ab0, 0);
    chk("wtf_code", err_code, 0);

    do_cmd("WTF", 0, 999, 0, -1, 0);
    chk("notmo_latency", ack_cyc - acc_cyc, 1002);
    chk("notmo_code", err_code, 0);
    chk("dir_cmd_cnt", cmd_cnt, STATS ? 6 : 0);
    chk("dir_err_cnt", err_cnt, STATS ? 3 : 0);

    for (int n = 0; n < 60; n++) begin
      int tmo, dk;
      tmo = $urandom_range(0, 6);
      dk  = $urandom_range(0, 8);
      if (tmo != 0 && $urandom_range(0, 4) == 0) dk = -1;
      do_cmd(ops[$urandom_range(0, 6)], tmo, dk, 1'($urandom), $urandom_range(0, 9), 1'($urandom));
      gap($urandom_range(0, 2));
    end

    // Reset in the middle of a WTD command.
    args[0] = "WTD";
    timeout = '0;
    args_valid = 1'b1;
    step();
    args_valid = 1'b0;
    set_exp(0, 4'b1000, 1, 0, 0, 0, 1);
    step();
    set_exp(0, 4'b1000, 0, 0, 0, 0, 1);
    step();
    #1;
    rst_n = 1'b0;
    m_cmd = 0; m_err = 0; m_code = 0;
    set_exp(0, 4'b0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_sel_now", sel, 0);
    chk("rst_busy_now", busy, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    set_exp(1, 4'b0, 0, 0, 0, 0, 0);
    step();
    do_cmd("SET", 0, 1, 0, -1, 0);
    chk("post_rst_code", err_code, 0);
    chk("post_rst_cmd_cnt", cmd_cnt, STATS ? 1 : 0);
    gap(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tb_cmd_dispatcher.md
Name: tb_cmd_dispatcher

Overview:
Sequential successor to the testbench command decoder. Accepts one tokenised scenario command (string argument array) per valid/ready handshake, decodes its opcode and drives a one-hot select plus a start pulse to the matching checker channel (SET, WAIT, CHECK, WTD). It then waits for that channel's done, applies a programmable timeout, and returns a one-cycle ack with a result code to the scenario reader.

Parameters:
ARGS_NB, 5, number of string tokens per command line.
TIMEOUT_W, 32, width of timeout value and cycle counter.
CNT_W, 16, width of statistics counters.

Ports:
clk  in  1  testbench clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
i_args  in  string[ARGS_NB]  command tokens; i_args[0] is the opcode.
i_args_valid  in  1  command present.
o_args_ready  out  1  dispatcher can accept a command.
i_timeout  in  TIMEOUT_W  max BUSY cycles per command; 0 disables the timeout.
o_sel  out  4  one-hot channel select: bit0 SET, bit1 WAIT, bit2 CHECK, bit3 WTD.
o_start  out  1  one-cycle start pulse to the selected channel.
o_wait_rise  out  1  WAIT edge type: 1 = WTR (rising), 0 = WTF (falling); valid while o_sel[1].
o_abort  out  1  one-cycle abort pulse to the selected channel on timeout.
i_done  in  4  per-channel completion, one bit per o_sel bit.
i_error  in  4  per-channel failure, sampled together with i_done.
o_ack  out  1  one-cycle command-complete pulse.
o_err_code  out  2  result: 0 OK, 1 UNKNOWN opcode, 2 TIMEOUT, 3 CHANNEL error; valid with o_ack.
o_busy  out  1  high in every state except IDLE.
o_cmd_cnt  out  CNT_W  commands completed.
o_err_cnt  out  CNT_W  commands completed with o_err_code != 0.

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE. All outputs are 0, including o_args_ready, o_sel, counters, o_err_code and o_wait_rise. Args latch is cleared to empty strings. After rst_n is released, o_args_ready rises at the first rising clk edge.
- Reset asserted mid-command: abort immediately without an ack. Channels see o_sel drop to 0.
- States: IDLE, DISPATCH, BUSY, ACK.
- IDLE:
  - o_args_ready=1.
  - On valid & ready at edge N: latch all i_args and go to DISPATCH.
  - The latched copy is used afterwards; later changes to i_args are ignored.
- DISPATCH (one cycle, N+1):
  - Decode the latched opcode: "SET" selects bit0. "WTR" selects bit1 with o_wait_rise=1. "WTF" selects bit1 with o_wait_rise=0. "CHK" selects bit2. "WTD" selects bit3.
  - Known opcode: o_sel one-hot, o_start=1, timeout counter cleared, then go to BUSY.
  - Unknown opcode: o_sel=0, no o_start, then go to ACK with code 1.
- BUSY:
  - o_sel is held and i_done is ignored on every bit except the selected one.
  - i_done[sel]=1 goes to ACK with code 3 if i_error[sel]=1, otherwise code 0.
  - Otherwise the counter increments.
  - If i_timeout != 0 and the counter equals i_timeout-1 with no done: o_abort=1 for that cycle, then go to ACK with code 2.
  - Done and timeout in the same cycle: done wins.
- ACK (one cycle):
  - o_ack=1, o_err_code valid, o_sel=0.
  - Counters update at the exit edge; o_cmd_cnt always increments, o_err_cnt only if code != 0.
  - Then go to IDLE.
- Minimum latency: accept at edge N, done at N+2, ack at N+3, next accept at N+4.
- o_err_code holds its value until the next ACK.
- Counters saturate at all-ones; they do not wrap.
- i_done is not sampled during the DISPATCH cycle.

Optional Feature:
TB_DISP_STATS_EN.
- Defined: o_cmd_cnt and o_err_cnt are live as described. Each ACK also prints via $display the simulation time, the opcode, all latched tokens and the result code.
- Undefined: counter logic is removed, o_cmd_cnt and o_err_cnt are tied to 0, and nothing is printed. All other behaviour is identical.

Test Plan:
- Reset, then "SET" valid at edge 0, i_done[0] at edge 2 -> o_sel=0001 and o_start in cycle 1, o_ack at edge 3, code 0, o_cmd_cnt=1.
- "WTR", i_timeout=10, no done -> o_sel=0010, o_wait_rise=1, o_abort after 10 BUSY cycles, o_ack next cycle with code 2, o_err_cnt=1.
- "XYZ" -> no o_start, o_ack two cycles after accept, code 1; o_args_ready low from the accept edge until after ACK.
- "CHK" with i_done[2] and i_error[2] in the same cycle, plus a spurious i_done[0] earlier -> the spurious done is ignored, ack code 3.
- "WTF", i_timeout=4, done arrives in the same cycle the counter hits 3 -> code 0, no o_abort; then i_timeout=0 with done after 1000 cycles -> code 0.
- rst_n pulsed low during BUSY of "WTD" -> o_sel, o_busy and counters go to 0 at once with no ack; o_args_ready rises at the first edge after release.
